share_buf_switch: RTL
=====================

// Module: share_buf_switch
// PURPOSE
//  Shared-buffer N-port cell switch: input ports push cells {rx_port,tx_port,data} via valid/ready into one
//  common cell buffer; per-destination address queues deliver each cell, in arrival order, to output port rx_port.
//  Successor to switch_moudle: parametrised depth, round-robin ingress/egress arbitration, output backpressure.
// PARAMETERS
//  PORT_NUB     4   number of input and output ports (>=2)
//  DATA_WIDTH   8   payload width
//  BUF_DEPTH    16  shared cell buffer entries (power of 2); every per-output queue is BUF_DEPTH deep
//  QUEUE_LIMIT  8   max cells queued per output (used only with SWITCH_OCC_LIMIT_EN)
//  derived: WIDTH_SEL=$clog2(PORT_NUB); WIDTH_PORT=1+2*WIDTH_SEL+DATA_WIDTH; AW=$clog2(BUF_DEPTH)
// PORTS
//  clk        in   1                     clock
//  rst_n      in   1                     async reset, active low
//  port_in    in   PORT_NUB*WIDTH_PORT   per port i, slice [(i+1)*WIDTH_PORT-1 : i*WIDTH_PORT] = {valid,rx_port,tx_port,data}
//  in_ready   out  PORT_NUB              cell on port i accepted in cycles where valid & in_ready[i]
//  port_out   out  PORT_NUB*WIDTH_PORT   same packing; valid bit = output register occupied
//  out_ready  in   PORT_NUB              port_out[o] consumed in cycles where valid & out_ready[o]
//  free_cnt   out  AW+1                  free buffer entries
//  drop_cnt   out  8                     saturating count of cells with rx_port >= PORT_NUB
// BEHAVIOUR
//  Reset (async assert, sync release): free list = addresses 0..BUF_DEPTH-1; all queues empty; all port_out valid=0;
//   free_cnt=BUF_DEPTH; drop_cnt=0; both RR pointers=0; in_ready=0. Reset mid-traffic discards all cells.
//  Ingress: one cell per cycle. Eligible port i: valid set and (free_cnt!=0, or rx_port>=PORT_NUB).
//   RR arbiter starts at wr_ptr; in_ready[i]=1 only for grant (combinational from valid; never 1 without valid).
//   On grant: pop free address, write cell to buffer, push address to queue[rx_port]; wr_ptr <= grant+1 (wrap).
//   rx_port>=PORT_NUB: cell accepted and discarded, no address used, drop_cnt+1 (saturate at 255).
//  Egress: one buffer read per cycle, combinational read of register array. Eligible output o: queue[o]
//   non-empty and (port_out[o] invalid or out_ready[o]=1). RR from rd_ptr; on grant: pop queue[o], load cell
//   into port_out[o] register, push address to free list same edge; rd_ptr <= grant+1.
//  Output register: out_ready with no reload -> valid <= 0; out_ready with reload -> back-to-back, no bubble.
//   valid with out_ready=0 holds all fields stable.
//  Latency: accepted in cycle T -> earliest port_out valid from T+2. tx_port/data passed unmodified.
//  Same-cycle alloc+free: free_cnt unchanged; freed address usable from next cycle only (no same-cycle reuse).
//  free_cnt=0: all in_ready=0 except invalid-destination drops. Queues cannot overflow (depth=BUF_DEPTH).
//  Ordering: cells to one output leave in acceptance order; no loss, duplication or reordering.
//  Capacity per output when stalled: BUF_DEPTH queued + 1 in output register.
// CONFIGURATION
//  SWITCH_OCC_LIMIT_EN defined: per-output occupancy counter (queued cells, AW+1 bits); port i ineligible at ingress
//   while occ[rx_port]==QUEUE_LIMIT, preventing one congested output from starving others of buffer space.
//  Undefined: no counters; any single output may occupy the whole buffer.
// TESTING
//  1 Reset, all valid=0 -> free_cnt=16, all port_out valid=0, in_ready=0, drop_cnt=0.
//  2 in0 cell {rx=3,tx=0,data=0xA5} accepted cycle T, out_ready=1 -> port_out[3]={1,3,0,0xA5} in T+2 only;
//    free_cnt 15 at T+1, 16 at T+2.
//  3 All 4 inputs valid same cycle, rx=3-j, tx=j, out_ready=1 -> grants 0,1,2,3 in consecutive cycles;
//    each output o receives exactly one cell with tx=3-o.
//  4 out_ready[0]=0, in1 sends 20 cells to port 0 -> 17 accepted, then in_ready[1]=0, free_cnt=0;
//    with SWITCH_OCC_LIMIT_EN: 9 accepted, and in2 cells to port 1 still accepted and delivered.
//  5 5 cells to port 2 data 1..5, out_ready[2] toggled 1/0 each cycle -> delivered 1,2,3,4,5, each once, in order.
//  6 rst_n low mid-traffic -> port_out valid=0 immediately; after release free_cnt=16, no stale cells emerge.

Source files
------------

// File: rtl/share_buf_switch.sv
// share_buf_switch: shared-buffer N-port cell switch.
// Input ports push {rx_port,tx_port,data} cells into one common cell buffer; a
// free-address list hands out buffer slots and per-output address queues return
// them to the output registers in arrival order.
// Optional feature macro: SWITCH_OCC_LIMIT_EN caps queued cells per output at
// QUEUE_LIMIT so one congested output cannot take every buffer slot.
module share_buf_switch #(
  parameter int PORT_NUB    = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BUF_DEPTH   = 16,
`ifdef SWITCH_OCC_LIMIT_EN
  parameter int QUEUE_LIMIT = 8,
`endif
  localparam int WIDTH_SEL  = $clog2(PORT_NUB),
  localparam int WIDTH_PORT = 1 + 2*WIDTH_SEL + DATA_WIDTH,
  localparam int AW         = $clog2(BUF_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORT_NUB*WIDTH_PORT-1:0] port_in,
  output logic [PORT_NUB-1:0]            in_ready,
  output logic [PORT_NUB*WIDTH_PORT-1:0] port_out,
  input  logic [PORT_NUB-1:0]            out_ready,
  output logic [AW:0]                    free_cnt,
  output logic [7:0]                     drop_cnt
);

  localparam int             CELL_W   = WIDTH_PORT - 1;
  localparam logic [AW:0]    BUF_FULL = (AW+1)'(BUF_DEPTH);

  logic [AW-1:0]        r_freeMem [BUF_DEPTH];
  logic [AW-1:0]        r_freeHead;
  logic [AW-1:0]        r_freeTail;
  logic [AW:0]          r_freeCnt;
  logic [CELL_W-1:0]    r_cellMem [BUF_DEPTH];
  logic [AW-1:0]        r_qMem [PORT_NUB][BUF_DEPTH];
  logic [AW:0]          r_qWr [PORT_NUB];
  logic [AW:0]          r_qRd [PORT_NUB];
  logic [PORT_NUB-1:0]  r_outValid;
  logic [CELL_W-1:0]    r_outCell [PORT_NUB];
  logic [WIDTH_SEL-1:0] r_wrPtr;
  logic [WIDTH_SEL-1:0] r_rdPtr;
  logic [7:0]           r_dropCnt;

  logic [CELL_W-1:0]    w_inCell [PORT_NUB];
  logic [WIDTH_SEL-1:0] w_inRx [PORT_NUB];
  logic [PORT_NUB-1:0]  w_inValid;
  logic [PORT_NUB-1:0]  w_inDrop;
  logic [PORT_NUB-1:0]  w_inElig;
  logic                 w_inGnt;
  logic [WIDTH_SEL-1:0] w_inIdx;
  logic [WIDTH_SEL-1:0] w_inNext;
  logic [CELL_W-1:0]    w_gntCell;
  logic [WIDTH_SEL-1:0] w_gntRx;
  logic                 w_gntDrop;
  logic                 w_alloc;
  logic [AW-1:0]        w_freeAddr;
  logic [PORT_NUB-1:0]  w_outElig;
  logic                 w_outGnt;
  logic [WIDTH_SEL-1:0] w_outIdx;
  logic [WIDTH_SEL-1:0] w_outNext;
  logic [AW-1:0]        w_rdAddr;
  logic [CELL_W-1:0]    w_rdCell;

`ifdef SWITCH_OCC_LIMIT_EN
  logic [AW:0]          w_occ [PORT_NUB];

  // Queued-cell count per output, taken from the queue pointer distance
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) begin
      w_occ[o] = r_qWr[o] - r_qRd[o];
    end
  end
`endif

  // Unpack input cells and decide which inputs may be granted this cycle
  always_comb begin
    for (int i = 0; i < PORT_NUB; i++) begin
      w_inValid[i] = port_in[i*WIDTH_PORT + CELL_W];
      w_inCell[i]  = port_in[i*WIDTH_PORT +: CELL_W];
      w_inRx[i]    = port_in[i*WIDTH_PORT + CELL_W - 1 -: WIDTH_SEL];
      w_inDrop[i]  = int'(w_inRx[i]) >= PORT_NUB;
      w_inElig[i]  = w_inValid[i] && (w_inDrop[i] || (r_freeCnt != '0));
`ifdef SWITCH_OCC_LIMIT_EN
      if (!w_inDrop[i] && (int'(w_occ[w_inRx[i]]) == QUEUE_LIMIT)) begin
        w_inElig[i] = 1'b0;
      end
`endif
    end
  end

  // Ingress round-robin: first eligible input at or after r_wrPtr wins
  always_comb begin
    logic [WIDTH_SEL-1:0] idx;
    idx      = '0;
    w_inGnt  = 1'b0;
    w_inIdx  = '0;
    for (int k = 0; k < PORT_NUB; k++) begin
      idx = WIDTH_SEL'((int'(r_wrPtr) + k) % PORT_NUB);
      if (!w_inGnt && w_inElig[idx]) begin
        w_inGnt = 1'b1;
        w_inIdx = idx;
      end
    end
    w_inNext   = WIDTH_SEL'((int'(w_inIdx) + 1) % PORT_NUB);
    w_gntCell  = w_inCell[w_inIdx];
    w_gntRx    = w_inRx[w_inIdx];
    w_gntDrop  = w_inDrop[w_inIdx];
    w_alloc    = w_inGnt && !w_gntDrop;
    w_freeAddr = r_freeMem[r_freeHead];
    in_ready   = '0;
    // Handshake stays closed while held in reset so no source sees a false accept
    if (w_inGnt) begin
      in_ready[w_inIdx] = rst_n;
    end
  end

  // Egress round-robin over outputs with queued cells and a free/draining register
  always_comb begin
    logic [WIDTH_SEL-1:0] idx;
    idx      = '0;
    w_outGnt = 1'b0;
    w_outIdx = '0;
    for (int o = 0; o < PORT_NUB; o++) begin
      w_outElig[o] = (r_qWr[o] != r_qRd[o]) && (!r_outValid[o] || out_ready[o]);
    end
    for (int k = 0; k < PORT_NUB; k++) begin
      idx = WIDTH_SEL'((int'(r_rdPtr) + k) % PORT_NUB);
      if (!w_outGnt && w_outElig[idx]) begin
        w_outGnt = 1'b1;
        w_outIdx = idx;
      end
    end
    w_outNext = WIDTH_SEL'((int'(w_outIdx) + 1) % PORT_NUB);
    w_rdAddr  = r_qMem[w_outIdx][r_qRd[w_outIdx][AW-1:0]];
    w_rdCell  = r_cellMem[w_rdAddr];
  end

  // Free-address list: pop on allocation, push the address read out on egress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < BUF_DEPTH; a++) begin
        r_freeMem[a] <= AW'(a);
      end
      r_freeHead <= '0;
      r_freeTail <= '0;
      r_freeCnt  <= BUF_FULL;
    end else begin
      if (w_outGnt) begin
        r_freeMem[r_freeTail] <= w_rdAddr;
        r_freeTail            <= r_freeTail + 1'b1;
      end
      if (w_alloc) begin
        r_freeHead <= r_freeHead + 1'b1;
      end
      if (w_outGnt && !w_alloc) begin
        r_freeCnt <= r_freeCnt + 1'b1;
      end else if (!w_outGnt && w_alloc) begin
        r_freeCnt <= r_freeCnt - 1'b1;
      end
    end
  end

  // Cell storage and queue entries carry no reset; pointers decide what is live
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_cellMem[w_freeAddr]                      <= w_gntCell;
      r_qMem[w_gntRx][r_qWr[w_gntRx][AW-1:0]]    <= w_freeAddr;
    end
  end

  // Per-output queue pointers; the extra bit separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < PORT_NUB; o++) begin
        r_qWr[o] <= '0;
        r_qRd[o] <= '0;
      end
    end else begin
      if (w_alloc) begin
        r_qWr[w_gntRx] <= r_qWr[w_gntRx] + 1'b1;
      end
      if (w_outGnt) begin
        r_qRd[w_outIdx] <= r_qRd[w_outIdx] + 1'b1;
      end
    end
  end

  // Output registers: reload back-to-back, drain on out_ready, hold when stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= '0;
      for (int o = 0; o < PORT_NUB; o++) begin
        r_outCell[o] <= '0;
      end
    end else begin
      for (int o = 0; o < PORT_NUB; o++) begin
        if (w_outGnt && (int'(w_outIdx) == o)) begin
          r_outValid[o] <= 1'b1;
          r_outCell[o]  <= w_rdCell;
        end else if (out_ready[o]) begin
          r_outValid[o] <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointers advance past each grant; drops count with saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_dropCnt <= '0;
    end else begin
      if (w_inGnt) begin
        r_wrPtr <= w_inNext;
      end
      if (w_outGnt) begin
        r_rdPtr <= w_outNext;
      end
      if (w_inGnt && w_gntDrop && (r_dropCnt != 8'hFF)) begin
        r_dropCnt <= r_dropCnt + 1'b1;
      end
    end
  end

  // Repack output registers onto the flat output bus
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) begin
      port_out[o*WIDTH_PORT +: WIDTH_PORT] = {r_outValid[o], r_outCell[o]};
    end
    free_cnt = r_freeCnt;
    drop_cnt = r_dropCnt;
  end

endmodule
